// File: rtl/noc_data_out_pio_if.sv
// Bus bundle for noc_data_out_pio: Avalon-MM register access plus the NoC valid/ready output stream.
interface noc_data_out_pio_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic [DATA_W-1:0] out_port;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  address, chipselect, write_n, writedata, out_ready,
    output readdata, out_port, out_valid
  );

  modport master (
    output address, chipselect, write_n, writedata, out_ready,
    input  readdata, out_port, out_valid
  );
endinterface

// File: rtl/noc_data_out_pio.sv
// NoC output PIO: CPU writes to DATA are queued and streamed out on a valid/ready port.
// Define NOC_OUT_PIO_IRQ_EN to add the irq output and the CONTROL irq_mask bit.
module noc_data_out_pio #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  noc_data_out_pio_if.slave  bus
`ifdef NOC_OUT_PIO_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              enable_q, enable_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
`ifdef NOC_OUT_PIO_IRQ_EN
  logic              irq_mask_q, irq_mask_d;
  logic              irq_q, irq_d;
`endif

  logic wr_en, push_req, push_ok, ctrl_wr, flush, pop, full, empty, valid;
  logic [DATA_W-1:0] status_w, control_w;

  assign wr_en    = bus.chipselect & ~bus.write_n;
  assign push_req = wr_en & (bus.address == ADDR_DATA);
  assign ctrl_wr  = wr_en & (bus.address == ADDR_CONTROL);
  assign flush    = ctrl_wr & bus.writedata[1];
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign valid    = enable_q & ~empty;
  assign pop      = valid & bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the word.
  assign push_ok  = push_req & (~full | pop);

  assign bus.out_valid = valid;
  assign bus.out_port  = mem_q[rd_ptr_q];
  assign bus.readdata  = readdata_q;

  always_comb begin
    status_w    = '0;
    status_w[0] = full;
    status_w[1] = empty;
    status_w[7:4] = 4'(count_q);
    status_w[8] = overflow_q;
    control_w    = '0;
    control_w[0] = enable_q;
`ifdef NOC_OUT_PIO_IRQ_EN
    control_w[2] = irq_mask_q;
`endif
  end

  // NOTE: every variable gets a default first so no path through this block infers a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    enable_d   = enable_q;
    last_d     = last_q;
`ifdef NOC_OUT_PIO_IRQ_EN
    irq_mask_d = irq_mask_q;
    irq_d      = irq_mask_q & empty & ~flush;
`endif
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        last_d   = mem_q[rd_ptr_q];
      end
      case ({push_ok, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (push_req && !push_ok) overflow_d = 1'b1;
    end
    if (ctrl_wr) begin
      enable_d = bus.writedata[0];
`ifdef NOC_OUT_PIO_IRQ_EN
      irq_mask_d = bus.writedata[2];
`endif
    end
    case (bus.address)
      ADDR_DATA:    readdata_d = last_q;
      ADDR_STATUS:  readdata_d = status_w;
      ADDR_CONTROL: readdata_d = control_w;
      default:      readdata_d = '0;
    endcase
    readdata_d = readdata_d & {DATA_W{bus.chipselect}};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      enable_q   <= 1'b1;
      last_q     <= '0;
      readdata_q <= '0;
`ifdef NOC_OUT_PIO_IRQ_EN
      irq_mask_q <= 1'b0;
      irq_q      <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      enable_q   <= enable_d;
      last_q     <= last_d;
      readdata_q <= readdata_d;
`ifdef NOC_OUT_PIO_IRQ_EN
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
`endif
    end
  end

  // NOTE: storage is left unreset; count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.writedata;
  end

`ifdef NOC_OUT_PIO_IRQ_EN
  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_noc_data_out_pio.sv
// Directed bench for noc_data_out_pio: register map, FIFO ordering, overflow, enable, flush and reset.
module tb_noc_data_out_pio;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  noc_data_out_pio_if #(.DATA_W(32)) bus ();

`ifdef NOC_OUT_PIO_IRQ_EN
  logic irq;
  noc_data_out_pio #(.DATA_W(32), .FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .irq(irq));
`else
  noc_data_out_pio #(.DATA_W(32), .FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
`endif

  // Inputs change and outputs are sampled on the falling edge, half a cycle from the active edge.
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = addr; bus.writedata = data;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = addr;
    @(negedge clk);
    data = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic expect_head(input string name, input logic [31:0] word);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_port !== word) begin
      $display("FAIL %s: valid=%b port=%h expected valid=1 port=%h", name, bus.out_valid, bus.out_port, word);
      bad++;
    end
    pop_one();
  endtask

  task automatic expect_status(input string name, input logic [31:0] exp);
    bus_read(2'd1, rd);
    total++;
    if (rd !== exp) begin
      $display("FAIL %s: status=%h expected %h", name, rd, exp);
      bad++;
    end
  endtask

  task automatic expect_idle(input string name);
    total++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL %s: out_valid=%b expected 0", name, bus.out_valid);
      bad++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    expect_idle("reset_valid");
    total++;
    if (bus.readdata !== 32'h0) begin
      $display("FAIL reset_readdata: got %h expected 0", bus.readdata); bad++;
    end
    @(negedge clk); reset_n = 1'b1;
    expect_status("reset_status", 32'h002);
    bus_read(2'd2, rd);
    total++;
    if (rd !== 32'h1) begin $display("FAIL reset_control: got %h expected 1", rd); bad++; end
    bus_read(2'd0, rd);
    total++;
    if (rd !== 32'h0) begin $display("FAIL reset_data: got %h expected 0", rd); bad++; end
    expect_idle("reset_valid_after");
  endtask

  task automatic test_single();
    bus_write(2'd0, 32'hA5A5_0001);
    expect_status("single_count", 32'h010);
    expect_head("single_head", 32'hA5A5_0001);
    expect_idle("single_drained");
    bus_read(2'd0, rd);
    total++;
    if (rd !== 32'hA5A5_0001) begin $display("FAIL single_last: got %h expected a5a50001", rd); bad++; end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) bus_write(2'd0, 32'h1000_0000 + i);
    expect_status("ovf_status", 32'h141);
    for (int i = 1; i <= 4; i++) expect_head("ovf_order", 32'h1000_0000 + i);
    expect_idle("ovf_drained");
    expect_status("ovf_sticky", 32'h102);
    bus_write(2'd2, 32'h3);
    expect_status("ovf_cleared", 32'h002);
  endtask

  task automatic test_push_pop_full();
    for (int i = 1; i <= 4; i++) bus_write(2'd0, 32'hB000_0000 + i);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 2'd0;
    bus.writedata = 32'hB000_0005; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.out_ready = 1'b0;
    expect_status("full_pushpop_status", 32'h041);
    for (int i = 2; i <= 5; i++) expect_head("full_pushpop_order", 32'hB000_0000 + i);
    expect_idle("full_pushpop_drained");
  endtask

  task automatic test_count_one();
    bus_write(2'd0, 32'hE000_0001);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 2'd0;
    bus.writedata = 32'hE000_0002; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.out_ready = 1'b0;
    expect_status("one_pushpop_status", 32'h010);
    expect_head("one_pushpop_head", 32'hE000_0002);
    expect_idle("one_pushpop_drained");
  endtask

  task automatic test_enable();
    bus_write(2'd2, 32'h0);
    bus.out_ready = 1'b1;
    bus_write(2'd0, 32'hC000_0001);
    bus_write(2'd0, 32'hC000_0002);
    expect_idle("disabled_valid");
    bus.out_ready = 1'b0;
    expect_status("disabled_status", 32'h020);
    bus_write(2'd2, 32'h1);
    expect_head("enabled_first", 32'hC000_0001);
    for (int i = 3; i <= 6; i++) bus_write(2'd0, 32'hC000_0000 + i);
    expect_status("enabled_overflow", 32'h141);
    bus_write(2'd2, 32'h3);
    expect_status("flush_status", 32'h002);
    expect_idle("flush_valid");
  endtask

  task automatic test_flush_pop();
    bus_write(2'd0, 32'hD000_0001);
    bus_write(2'd0, 32'hD000_0002);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 2'd2;
    bus.writedata = 32'h3; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.out_ready = 1'b0;
    expect_idle("flushpop_valid");
    expect_status("flushpop_status", 32'h002);
    bus_read(2'd0, rd);
    total++;
    if (rd !== 32'hC000_0001) begin $display("FAIL flushpop_last: got %h expected c0000001", rd); bad++; end
  endtask

  task automatic test_reserved();
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rd);
    total++;
    if (rd !== 32'h0) begin $display("FAIL reserved_read: got %h expected 0", rd); bad++; end
    bus_read(2'd2, rd);
    total++;
    if (rd !== 32'h1) begin $display("FAIL reserved_ctrl: got %h expected 1", rd); bad++; end
    @(negedge clk);
    bus.chipselect = 1'b0; bus.address = 2'd1;
    @(negedge clk);
    total++;
    if (bus.readdata !== 32'h0) begin $display("FAIL nocs_read: got %h expected 0", bus.readdata); bad++; end
  endtask

  task automatic test_reset_mid();
    bus_write(2'd0, 32'hF000_0001);
    bus_write(2'd0, 32'hF000_0002);
    bus.out_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    expect_idle("midreset_valid");
    @(negedge clk);
    bus.out_ready = 1'b0;
    reset_n = 1'b1;
    expect_status("midreset_status", 32'h002);
    expect_idle("midreset_after");
  endtask

`ifdef NOC_OUT_PIO_IRQ_EN
  task automatic test_irq();
    bus_write(2'd2, 32'h5);
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin $display("FAIL irq_empty: got %b expected 1", irq); bad++; end
    bus_write(2'd0, 32'h9000_0001);
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin $display("FAIL irq_pushed: got %b expected 0", irq); bad++; end
    pop_one();
    total++;
    if (irq !== 1'b0) begin $display("FAIL irq_pop_edge: got %b expected 0", irq); bad++; end
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin $display("FAIL irq_drained: got %b expected 1", irq); bad++; end
    reset_n = 1'b0;
    #1;
    total++;
    if (irq !== 1'b0) begin $display("FAIL irq_reset: got %b expected 0", irq); bad++; end
    @(negedge clk);
    reset_n = 1'b1;
  endtask
`endif

  initial begin
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus.writedata = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_overflow();
    test_push_pop_full();
    test_count_one();
    test_enable();
    test_flush_pop();
    test_reserved();
    test_reset_mid();
`ifdef NOC_OUT_PIO_IRQ_EN
    test_irq();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
